// File: rtl/aes_pkg.sv
// Shared constants and host-FSM state encoding for the AES statemt memory.
package aes_pkg;

   localparam int STATE_BYTES    = 16;
   localparam int STATEMT_ADDR_W = 5;
   localparam int STATEMT_DATA_W = 32;
   localparam int STATEMT_DEPTH  = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      UL_RD  = 2'd2,
      UL_OUT = 2'd3
   } host_state_e;

endpackage

// File: rtl/aes_dpram_wf.sv
// Bare two-port write-first RAM. Port A also carries a host slot with its own byte
// read register, so host reads never disturb the kernel-visible q_a.
module aes_dpram_wf
   import aes_pkg::*;
#(
   parameter int DATA_W = STATEMT_DATA_W,
   parameter int ADDR_W = STATEMT_ADDR_W,
   parameter int DEPTH  = STATEMT_DEPTH,
   parameter int HOST_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_a,
   input  logic              we_a,
   input  logic              sel_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] d_a,
   input  logic              ce_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] d_b,
   output logic [DATA_W-1:0] q_a,
   output logic [HOST_W-1:0] q_h,
   output logic [DATA_W-1:0] q_b,
   output logic              coll
);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic              wr_a_s;
   logic              wr_b_s;
   logic [DATA_W-1:0] rd_a_s;
   logic [DATA_W-1:0] rd_b_s;

   assign wr_a_s = ce_a & we_a;
   assign wr_b_s = ce_b & we_b;
   assign coll   = wr_a_s & wr_b_s & (addr_a == addr_b);
   // Each port sees its own write data; the other port sees the pre-edge contents.
   assign rd_a_s = we_a ? d_a : mem_r[addr_a];
   assign rd_b_s = we_b ? d_b : mem_r[addr_b];

   // Storage array; port A is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (wr_b_s) begin
         mem_r[addr_b] <= d_b;
      end
      if (wr_a_s) begin
         mem_r[addr_a] <= d_a;
      end
   end

   // Read-data registers, holding whenever their slot is not enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_a <= {DATA_W{1'b0}};
         q_h <= {HOST_W{1'b0}};
         q_b <= {DATA_W{1'b0}};
      end else begin
         if (ce_a && !sel_a) begin
            q_a <= rd_a_s;
         end
         if (ce_a && sel_a) begin
            q_h <= rd_a_s[HOST_W-1:0];
         end
         if (ce_b) begin
            q_b <= rd_b_s;
         end
      end
   end

endmodule

// File: rtl/aes_statemt_ram.sv
// AES statemt memory responder: dual kernel ports plus a host byte loader/unloader
// that owns port 0 whenever it is busy.
module aes_statemt_ram
   import aes_pkg::*;
#(
   parameter int DATA_W = STATEMT_DATA_W,
   parameter int ADDR_W = STATEMT_ADDR_W,
   parameter int DEPTH  = STATEMT_DEPTH,
   parameter int NBYTES = STATE_BYTES
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic [ADDR_W-1:0] statemt_address0,
   input  logic              statemt_ce0,
   input  logic              statemt_we0,
   input  logic [DATA_W-1:0] statemt_d0,
   output logic [DATA_W-1:0] statemt_q0,
   input  logic [ADDR_W-1:0] statemt_address1,
   input  logic              statemt_ce1,
   input  logic              statemt_we1,
   input  logic [DATA_W-1:0] statemt_d1,
   output logic [DATA_W-1:0] statemt_q1,
   input  logic              ld_start,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [7:0]        ld_data,
   output logic              ld_done,
   input  logic              ul_start,
   output logic              ul_valid,
   input  logic              ul_ready,
   output logic [7:0]        ul_data,
   output logic              ul_done,
   output logic              busy,
   output logic              coll_err
);

   localparam int              IDX_W    = $clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   host_state_e       state_r;
   logic [IDX_W-1:0]  idx_r;
   logic              ld_ready_r;
   logic              ld_done_r;
   logic              ul_valid_r;
   logic              ul_done_r;
   logic              busy_r;
   logic              coll_err_r;

   logic              ram_ce_a_s;
   logic              ram_we_a_s;
   logic              ram_sel_a_s;
   logic [ADDR_W-1:0] ram_addr_a_s;
   logic [DATA_W-1:0] ram_d_a_s;
   logic              ram_ce_b_s;
   logic              ram_we_b_s;
   logic [7:0]        ram_q_h_s;
   logic              ram_coll_s;

   // Port-0 slot mux: kernel in IDLE, host slot in LOAD/UL_RD, quiet otherwise.
   always_comb begin
      ram_ce_a_s   = 1'b0;
      ram_we_a_s   = 1'b0;
      ram_sel_a_s  = 1'b0;
      ram_addr_a_s = {ADDR_W{1'b0}};
      ram_d_a_s    = {DATA_W{1'b0}};
      if (ap_rst) begin
         ram_ce_a_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               ram_ce_a_s   = statemt_ce0;
               ram_we_a_s   = statemt_we0;
               ram_addr_a_s = statemt_address0;
               ram_d_a_s    = statemt_d0;
            end
            LOAD: begin
               ram_ce_a_s   = ld_valid;
               ram_we_a_s   = 1'b1;
               ram_sel_a_s  = 1'b1;
               ram_addr_a_s = {{(ADDR_W-IDX_W){1'b0}}, idx_r};
               ram_d_a_s    = {{(DATA_W-8){1'b0}}, ld_data};
            end
            UL_RD: begin
               ram_ce_a_s   = 1'b1;
               ram_sel_a_s  = 1'b1;
               ram_addr_a_s = {{(ADDR_W-IDX_W){1'b0}}, idx_r};
            end
            default: begin
               ram_ce_a_s = 1'b0;
            end
         endcase
      end
   end

   // Kernel port 1 is gated off whenever the host owns the memory.
   always_comb begin
      ram_ce_b_s = 1'b0;
      ram_we_b_s = 1'b0;
      if (!ap_rst && (state_r == IDLE)) begin
         ram_ce_b_s = statemt_ce1;
         ram_we_b_s = statemt_we1;
      end else begin
         ram_ce_b_s = 1'b0;
         ram_we_b_s = 1'b0;
      end
   end

   aes_dpram_wf #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .HOST_W (8)
   ) u_ram (
      .clk    (ap_clk),
      .rst    (ap_rst),
      .ce_a   (ram_ce_a_s),
      .we_a   (ram_we_a_s),
      .sel_a  (ram_sel_a_s),
      .addr_a (ram_addr_a_s),
      .d_a    (ram_d_a_s),
      .ce_b   (ram_ce_b_s),
      .we_b   (ram_we_b_s),
      .addr_b (statemt_address1),
      .d_b    (statemt_d1),
      .q_a    (statemt_q0),
      .q_h    (ram_q_h_s),
      .q_b    (statemt_q1),
      .coll   (ram_coll_s)
   );

   // Host FSM with registered handshake, done pulses, busy and sticky collision flag.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_r    <= IDLE;
         idx_r      <= {IDX_W{1'b0}};
         ld_ready_r <= 1'b0;
         ld_done_r  <= 1'b0;
         ul_valid_r <= 1'b0;
         ul_done_r  <= 1'b0;
         busy_r     <= 1'b0;
         coll_err_r <= 1'b0;
      end else begin
         ld_done_r <= 1'b0;
         ul_done_r <= 1'b0;
         if (ram_coll_s) begin
            coll_err_r <= 1'b1;
         end
         case (state_r)
            IDLE: begin
               if (ld_start) begin
                  state_r    <= LOAD;
                  idx_r      <= {IDX_W{1'b0}};
                  ld_ready_r <= 1'b1;
                  busy_r     <= 1'b1;
               end else if (ul_start) begin
                  state_r <= UL_RD;
                  idx_r   <= {IDX_W{1'b0}};
                  busy_r  <= 1'b1;
               end
            end
            LOAD: begin
               if (ld_valid) begin
                  if (idx_r == LAST_IDX) begin
                     state_r    <= IDLE;
                     ld_ready_r <= 1'b0;
                     ld_done_r  <= 1'b1;
                     busy_r     <= 1'b0;
                  end else begin
                     idx_r <= idx_r + IDX_W'(1'b1);
                  end
               end
            end
            UL_RD: begin
               state_r    <= UL_OUT;
               ul_valid_r <= 1'b1;
            end
            UL_OUT: begin
               if (ul_ready) begin
                  ul_valid_r <= 1'b0;
                  if (idx_r == LAST_IDX) begin
                     state_r   <= IDLE;
                     ul_done_r <= 1'b1;
                     busy_r    <= 1'b0;
                  end else begin
                     idx_r   <= idx_r + IDX_W'(1'b1);
                     state_r <= UL_RD;
                  end
               end
            end
            default: begin
               state_r    <= IDLE;
               ld_ready_r <= 1'b0;
               ul_valid_r <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign ld_ready = ld_ready_r;
   assign ld_done  = ld_done_r;
   assign ul_valid = ul_valid_r;
   assign ul_data  = ram_q_h_s;
   assign ul_done  = ul_done_r;
   assign busy     = busy_r;
   assign coll_err = coll_err_r;

endmodule

// File: tb/tb_aes_statemt_ram.sv
// Directed bench for aes_statemt_ram: reference memory model plus expected-value queues.
module tb_aes_statemt_ram;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic [4:0]  statemt_address0, statemt_address1;
   logic        statemt_ce0, statemt_we0, statemt_ce1, statemt_we1;
   logic [31:0] statemt_d0, statemt_d1, statemt_q0, statemt_q1;
   logic        ld_start, ld_valid, ld_ready, ld_done;
   logic [7:0]  ld_data, ul_data;
   logic        ul_start, ul_valid, ul_ready, ul_done, busy, coll_err;

   int checks   = 0;
   int failures = 0;

   logic [31:0] model [32];
   logic [31:0] q0_last, q1_last;
   logic [31:0] q0_exp_q [$];
   logic [31:0] q1_exp_q [$];
   logic [7:0]  ul_exp_q [$];

   always #5 ap_clk = ~ap_clk;

   aes_statemt_ram dut (
      .ap_clk           (ap_clk),
      .ap_rst           (ap_rst),
      .statemt_address0 (statemt_address0),
      .statemt_ce0      (statemt_ce0),
      .statemt_we0      (statemt_we0),
      .statemt_d0       (statemt_d0),
      .statemt_q0       (statemt_q0),
      .statemt_address1 (statemt_address1),
      .statemt_ce1      (statemt_ce1),
      .statemt_we1      (statemt_we1),
      .statemt_d1       (statemt_d1),
      .statemt_q1       (statemt_q1),
      .ld_start         (ld_start),
      .ld_valid         (ld_valid),
      .ld_ready         (ld_ready),
      .ld_data          (ld_data),
      .ld_done          (ld_done),
      .ul_start         (ul_start),
      .ul_valid         (ul_valid),
      .ul_ready         (ul_ready),
      .ul_data          (ul_data),
      .ul_done          (ul_done),
      .busy             (busy),
      .coll_err         (coll_err)
   );

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One kernel cycle on both ports; expectations come from the reference model.
   task automatic k_access(input string tag,
                           input logic c0, input logic w0, input logic [4:0] a0, input logic [31:0] v0,
                           input logic c1, input logic w1, input logic [4:0] a1, input logic [31:0] v1);
      statemt_ce0 = c0; statemt_we0 = w0; statemt_address0 = a0; statemt_d0 = v0;
      statemt_ce1 = c1; statemt_we1 = w1; statemt_address1 = a1; statemt_d1 = v1;
      if (c0) q0_last = w0 ? v0 : model[a0];
      if (c1) q1_last = w1 ? v1 : model[a1];
      q0_exp_q.push_back(q0_last);
      q1_exp_q.push_back(q1_last);
      if (c1 && w1) model[a1] = v1;
      if (c0 && w0) model[a0] = v0;
      step();
      statemt_ce0 = 1'b0; statemt_we0 = 1'b0; statemt_ce1 = 1'b0; statemt_we1 = 1'b0;
      check({tag, ".q0"}, statemt_q0, q0_exp_q.pop_front());
      check({tag, ".q1"}, statemt_q1, q1_exp_q.pop_front());
   endtask

   // Feeds base+0..base+15 with ld_valid high; assumes LOAD was just entered.
   task automatic host_feed(input logic [7:0] base, output int rdy_cnt, output int done_cnt, output int nb);
      nb = 0; rdy_cnt = 0; done_cnt = 0;
      ld_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         logic acc;
         ld_data = base + nb[7:0];
         acc = ld_ready && ld_valid;
         if (ld_ready) rdy_cnt++;
         if (acc) model[nb[4:0]] = {24'h000000, base + nb[7:0]};
         step();
         if (acc) nb++;
         if (ld_done) done_cnt++;
         if (nb >= 16) ld_valid = 1'b0;
      end
      ld_valid = 1'b0;
   endtask

   // Unloads all 16 bytes with ul_ready cycling 1,0,0,1.
   task automatic host_unload(output int done_cnt, output int acc_cnt);
      logic [3:0] pat;
      pat = 4'b1001;
      done_cnt = 0; acc_cnt = 0;
      for (int i = 0; i < 16; i++) ul_exp_q.push_back(model[i][7:0]);
      ul_start = 1'b1;
      step();
      ul_start = 1'b0;
      for (int c = 0; c < 200; c++) begin
         logic acc;
         ul_ready = pat[c % 4];
         acc = ul_valid && ul_ready;
         if (ul_valid && (ul_exp_q.size() > 0)) begin
            if (acc) check("ul_data", {24'h000000, ul_data}, {24'h000000, ul_exp_q.pop_front()});
            else     check("ul_hold", {24'h000000, ul_data}, {24'h000000, ul_exp_q[0]});
         end
         step();
         if (acc) acc_cnt++;
         if (ul_done) done_cnt++;
      end
      ul_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rdy, dn, nb, acc;
      ap_rst = 1'b1;
      statemt_address0 = 5'd0; statemt_ce0 = 1'b0; statemt_we0 = 1'b0; statemt_d0 = 32'h0;
      statemt_address1 = 5'd0; statemt_ce1 = 1'b0; statemt_we1 = 1'b0; statemt_d1 = 32'h0;
      ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
      ul_start = 1'b0; ul_ready = 1'b0;
      step(); step();
      check("rst.q0", statemt_q0, 32'h0);
      check("rst.q1", statemt_q1, 32'h0);
      check("rst.ctl", {25'h0, ld_ready, ld_done, ul_valid, ul_done, busy, coll_err, 1'b0},
            32'h0);
      check("rst.ul_data", {24'h0, ul_data}, 32'h0);
      ap_rst = 1'b0;
      q0_last = 32'h0; q1_last = 32'h0;

      // Host load 0x00..0x0F
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      check("load.busy", {31'h0, busy}, 32'h1);
      host_feed(8'h00, rdy, dn, nb);
      check("load.ready_cycles", rdy, 32'd16);
      check("load.done_pulses", dn, 32'd1);
      check("load.bytes", nb, 32'd16);
      check("load.busy_after", {31'h0, busy}, 32'h0);

      // Kernel reads, write-first and cross-port read-before-write
      k_access("rd5",      1'b1, 1'b0, 5'd5,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0);
      k_access("rd3_p1",   1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd3,  32'h0);
      k_access("wr3_rd3",  1'b1, 1'b1, 5'd3,  32'hDEADBEEF, 1'b1, 1'b0, 5'd3,  32'h0);
      k_access("rd3_next", 1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd3,  32'h0);
      k_access("wr9_rd9",  1'b1, 1'b0, 5'd9,  32'h0,        1'b1, 1'b1, 5'd9,  32'hA5A5A5A5);
      k_access("wr_diff",  1'b1, 1'b1, 5'd10, 32'h00001010, 1'b1, 1'b1, 5'd11, 32'h00001111);
      k_access("rd_diff",  1'b1, 1'b0, 5'd11, 32'h0,        1'b1, 1'b0, 5'd10, 32'h0);
      k_access("pre20",    1'b1, 1'b1, 5'd20, 32'h20202020, 1'b0, 1'b0, 5'd0,  32'h0);
      check("coll.before", {31'h0, coll_err}, 32'h0);

      // Same-address dual write
      k_access("coll",     1'b1, 1'b1, 5'd7,  32'h00000011, 1'b1, 1'b1, 5'd7,  32'h00000022);
      check("coll.set", {31'h0, coll_err}, 32'h1);
      k_access("rd7",      1'b1, 1'b0, 5'd7,  32'h0,        1'b1, 1'b0, 5'd7,  32'h0);
      k_access("idle",     1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0);
      check("coll.sticky", {31'h0, coll_err}, 32'h1);

      // Host unload with stalls
      host_unload(dn, acc);
      check("ul.accepts", acc, 32'd16);
      check("ul.done_pulses", dn, 32'd1);
      check("ul.queue_empty", ul_exp_q.size(), 32'd0);
      check("ul.busy_after", {31'h0, busy}, 32'h0);

      // Simultaneous starts: load wins, kernel write dropped while busy
      ld_start = 1'b1; ul_start = 1'b1;
      step();
      ld_start = 1'b0; ul_start = 1'b0;
      check("both.busy", {31'h0, busy}, 32'h1);
      check("both.ld_ready", {31'h0, ld_ready}, 32'h1);
      check("both.ul_valid", {31'h0, ul_valid}, 32'h0);
      statemt_ce0 = 1'b1; statemt_we0 = 1'b1; statemt_address0 = 5'd20; statemt_d0 = 32'hFFFFFFFF;
      q0_exp_q.push_back(q0_last);
      step();
      statemt_ce0 = 1'b0; statemt_we0 = 1'b0;
      check("busy.q0_hold", statemt_q0, q0_exp_q.pop_front());
      host_feed(8'h40, rdy, dn, nb);
      check("load2.done_pulses", dn, 32'd1);
      check("load2.ul_valid", {31'h0, ul_valid}, 32'h0);
      k_access("rd20",     1'b1, 1'b0, 5'd20, 32'h0,        1'b0, 1'b0, 5'd0,  32'h0);
      k_access("rd2",      1'b1, 1'b0, 5'd2,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0);

      // Reset in the middle of a load
      ld_start = 1'b1;
      step();
      ld_start = 1'b0;
      ld_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ld_data = 8'h80 + k[7:0];
         model[k] = {24'h000000, 8'h80 + k[7:0]};
         step();
      end
      ld_valid = 1'b0;
      ap_rst = 1'b1;
      step();
      check("abort.busy", {31'h0, busy}, 32'h0);
      check("abort.ld_ready", {31'h0, ld_ready}, 32'h0);
      check("abort.ld_done", {31'h0, ld_done}, 32'h0);
      check("abort.coll_err", {31'h0, coll_err}, 32'h0);
      check("abort.q0", statemt_q0, 32'h0);
      ap_rst = 1'b0;
      q0_last = 32'h0; q1_last = 32'h0;
      step();
      check("abort.no_done", {31'h0, ld_done}, 32'h0);
      for (int a = 0; a < 7; a++) begin
         k_access("abort.rd", 1'b1, 1'b0, a[4:0], 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
